// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries in program order at the tail, accepts
// out-of-order result writebacks by index, and retires completed entries in
// order from the head.
// Optional speculative flush is enabled by defining ROB_FLUSH_EN.
module reorder_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
`ifdef ROB_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [RD_W-1:0]   alloc_rd,
    output logic [$clog2(DEPTH)-1:0] alloc_idx,
    input  logic              wb_valid,
    input  logic [$clog2(DEPTH)-1:0] wb_idx,
    input  logic [DATA_W-1:0] wb_value,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [RD_W-1:0]   commit_rd,
    output logic [DATA_W-1:0] commit_value,
    output logic [$clog2(DEPTH)-1:0] commit_idx,
    output logic [$clog2(DEPTH):0]   count,
    output logic              empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  done;
    logic [RD_W-1:0]   rd_mem  [DEPTH];
    logic [DATA_W-1:0] val_mem [DEPTH];
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;

    logic clear;
    logic head_ready;
    logic alloc_fire;
    logic wb_fire;
    logic commit_fire;

    assign head_ready = busy[head] && done[head];

    // Clearing condition and handshake gating; a flush suppresses both handshakes
`ifdef ROB_FLUSH_EN
    assign clear        = rst || (flush && rdy);
    assign alloc_ready  = (count != CNT_W'(DEPTH)) && !(flush && rdy);
    assign commit_valid = head_ready && !(flush && rdy);
`else
    assign clear        = rst;
    assign alloc_ready  = (count != CNT_W'(DEPTH));
    assign commit_valid = head_ready;
`endif

    assign alloc_fire  = alloc_valid && alloc_ready && rdy;
    assign wb_fire     = wb_valid && rdy && busy[wb_idx];
    assign commit_fire = commit_valid && commit_ready && rdy;

    assign alloc_idx    = tail;
    assign commit_idx   = head;
    assign commit_rd    = rd_mem[head];
    assign commit_value = val_mem[head];
    assign empty        = (count == '0);

    // Control state: pointers, occupancy and per-entry busy/done flags
    always_ff @(posedge clk) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
        end else begin
            if (alloc_fire) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + IDX_W'(1);
            end
            if (wb_fire) begin
                done[wb_idx] <= 1'b1;
            end
            if (commit_fire) begin
                busy[head] <= 1'b0;
                head       <= head + IDX_W'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are meaningless until the entry is busy/done
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (alloc_fire) begin
                rd_mem[tail] <= alloc_rd;
            end
            if (wb_fire) begin
                val_mem[wb_idx] <= wb_value;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (DEPTH=4, DATA_W=32, RD_W=5).
// Allocations push expected retirements to a scoreboard queue; commits pop them.
module tb_reorder_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned IDX_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rdy = 1'b1;
`ifdef ROB_FLUSH_EN
    logic              flush = 1'b0;
`endif
    logic              alloc_valid = 1'b0;
    logic              alloc_ready;
    logic [RD_W-1:0]   alloc_rd = '0;
    logic [IDX_W-1:0]  alloc_idx;
    logic              wb_valid = 1'b0;
    logic [IDX_W-1:0]  wb_idx = '0;
    logic [DATA_W-1:0] wb_value = '0;
    logic              commit_valid;
    logic              commit_ready = 1'b0;
    logic [RD_W-1:0]   commit_rd;
    logic [DATA_W-1:0] commit_value;
    logic [IDX_W-1:0]  commit_idx;
    logic [IDX_W:0]    count;
    logic              empty;

    reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
`ifdef ROB_FLUSH_EN
        .flush        (flush),
`endif
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_rd     (alloc_rd),
        .alloc_idx    (alloc_idx),
        .wb_valid     (wb_valid),
        .wb_idx       (wb_idx),
        .wb_value     (wb_value),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_rd    (commit_rd),
        .commit_value (commit_value),
        .commit_idx   (commit_idx),
        .count        (count),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RD_W-1:0]  rd;
        logic [IDX_W-1:0] idx;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] m_val [DEPTH];
    logic [IDX_W-1:0]  m_tail;
    int                checks   = 0;
    int                failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        m_tail = '0;
    endtask

    task automatic alloc(input logic [RD_W-1:0] rd);
        exp_t e;
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        #1;
        check("alloc_ready", 64'(alloc_ready), 64'(1));
        check("alloc_idx", 64'(alloc_idx), 64'(m_tail));
        e.rd  = rd;
        e.idx = m_tail;
        sb.push_back(e);
        m_tail = m_tail + IDX_W'(1);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic wb(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] val, input bit model);
        wb_valid = 1'b1;
        wb_idx   = idx;
        wb_value = val;
        if (model) m_val[idx] = val;
        tick();
        wb_valid = 1'b0;
    endtask

    // Check the head against the oldest scoreboard entry without clocking
    task automatic check_head(input string tag);
        exp_t e;
        check({tag, "_valid"}, 64'(commit_valid), 64'(1));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_rd"}, 64'(commit_rd), 64'(e.rd));
            check({tag, "_idx"}, 64'(commit_idx), 64'(e.idx));
            check({tag, "_value"}, 64'(commit_value), 64'(m_val[e.idx]));
        end
    endtask

    task automatic do_commit(input string tag);
        commit_ready = 1'b1;
        #1;
        check_head(tag);
        tick();
        commit_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        do_reset();
        check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        check("rst_commit_valid", 64'(commit_valid), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_count", 64'(count), 64'(0));
        check("rst_alloc_idx", 64'(alloc_idx), 64'(0));

        // In-order retirement of out-of-order writebacks
        alloc(5'd1);
        alloc(5'd2);
        alloc(5'd3);
        check("io_count", 64'(count), 64'(3));
        wb(2'd2, 32'h33, 1'b1);
        check("io_head_not_done", 64'(commit_valid), 64'(0));
        wb_valid = 1'b1;
        wb_idx   = 2'd0;
        wb_value = 32'h11;
        m_val[0] = 32'h11;
        #1;
        check("io_no_bypass", 64'(commit_valid), 64'(0));
        tick();
        wb_valid = 1'b0;
        check("io_head_done_next", 64'(commit_valid), 64'(1));
        wb(2'd1, 32'h22, 1'b1);
        do_commit("io_c0");
        do_commit("io_c1");
        do_commit("io_c2");
        check("io_empty", 64'(empty), 64'(1));
        check("io_valid_after", 64'(commit_valid), 64'(0));

        // Full boundary and tail wrap
        do_reset();
        for (int i = 0; i < 4; i++) alloc(RD_W'(i + 4));
        check("full_count", 64'(count), 64'(4));
        check("full_ready", 64'(alloc_ready), 64'(0));
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        tick();
        alloc_valid = 1'b0;
        check("full_drop_count", 64'(count), 64'(4));
        wb(2'd0, 32'h44, 1'b1);
        do_commit("full_c0");
        check("full_ready_after", 64'(alloc_ready), 64'(1));
        check("full_wrap_idx", 64'(alloc_idx), 64'(0));
        alloc(5'd10);
        check("full_count2", 64'(count), 64'(4));

        // Simultaneous allocate, writeback and commit
        do_reset();
        alloc(5'd1);
        alloc(5'd2);
        wb(2'd0, 32'h55, 1'b1);
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        alloc_rd     = 5'd3;
        wb_valid     = 1'b1;
        wb_idx       = 2'd1;
        wb_value     = 32'h66;
        m_val[1]     = 32'h66;
        #1;
        check("sim_alloc_idx", 64'(alloc_idx), 64'(2));
        check_head("sim_c0");
        sb.push_back('{rd: 5'd3, idx: 2'd2});
        m_tail = 2'd3;
        tick();
        commit_ready = 1'b0;
        alloc_valid  = 1'b0;
        wb_valid     = 1'b0;
        check("sim_count", 64'(count), 64'(2));
        check("sim_head", 64'(commit_idx), 64'(1));
        check("sim_tail", 64'(alloc_idx), 64'(3));
        check("sim_wb_done", 64'(commit_valid), 64'(1));
        do_commit("sim_c1");

        // Pause: nothing moves while rdy is low
        wb(2'd2, 32'hAA, 1'b1);
        rdy          = 1'b0;
        alloc_valid  = 1'b1;
        alloc_rd     = 5'd7;
        commit_ready = 1'b1;
        wb_valid     = 1'b1;
        wb_idx       = 2'd3;
        wb_value     = 32'hBB;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_count", 64'(count), 64'(1));
            check("pause_head", 64'(commit_idx), 64'(2));
            check("pause_tail", 64'(alloc_idx), 64'(3));
            check("pause_cvalid", 64'(commit_valid), 64'(1));
            check("pause_cvalue", 64'(commit_value), 64'(32'hAA));
            check("pause_crd", 64'(commit_rd), 64'(3));
        end
        rdy          = 1'b1;
        alloc_valid  = 1'b0;
        commit_ready = 1'b0;
        wb_valid     = 1'b0;
        do_commit("pause_c0");
        check("pause_empty", 64'(empty), 64'(1));

        // Reset mid-operation discards entries and ignores same-cycle events
        do_reset();
        alloc(5'd1);
        alloc(5'd2);
        alloc(5'd3);
        wb(2'd0, 32'h77, 1'b1);
        rst          = 1'b1;
        commit_ready = 1'b1;
        wb_valid     = 1'b1;
        wb_idx       = 2'd1;
        wb_value     = 32'h88;
        tick();
        rst          = 1'b0;
        commit_ready = 1'b0;
        wb_valid     = 1'b0;
        sb.delete();
        m_tail = '0;
        check("mrst_count", 64'(count), 64'(0));
        check("mrst_empty", 64'(empty), 64'(1));
        check("mrst_cvalid", 64'(commit_valid), 64'(0));
        check("mrst_alloc_idx", 64'(alloc_idx), 64'(0));
        wb(2'd1, 32'h99, 1'b0);
        alloc(5'd4);
        alloc(5'd5);
        wb(2'd0, 32'h12, 1'b1);
        do_commit("mrst_c0");
        check("mrst_stale_wb", 64'(commit_valid), 64'(0));

`ifdef ROB_FLUSH_EN
        // Flush behaves like reset and masks both handshakes in its cycle
        do_reset();
        alloc(5'd1);
        alloc(5'd2);
        alloc(5'd3);
        wb(2'd0, 32'h21, 1'b1);
        flush        = 1'b1;
        alloc_valid  = 1'b1;
        commit_ready = 1'b1;
        wb_valid     = 1'b1;
        wb_idx       = 2'd1;
        wb_value     = 32'h31;
        #1;
        check("fl_cvalid_c", 64'(commit_valid), 64'(0));
        check("fl_aready_c", 64'(alloc_ready), 64'(0));
        tick();
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        commit_ready = 1'b0;
        wb_valid     = 1'b0;
        sb.delete();
        m_tail = '0;
        check("fl_count", 64'(count), 64'(0));
        check("fl_empty", 64'(empty), 64'(1));
        check("fl_cvalid", 64'(commit_valid), 64'(0));
        wb(2'd1, 32'h41, 1'b0);
        alloc(5'd6);
        alloc(5'd7);
        wb(2'd0, 32'h51, 1'b1);
        do_commit("fl_c0");
        check("fl_stale_wb", 64'(commit_valid), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries; a power of two, 2..64.
REQ-002 SHALL have parameter DATA_W, default 32, result value width.
REQ-003 SHALL have parameter RD_W, default 5, destination register address width.
REQ-004 SHALL derive localparam IDX_W = log2(DEPTH), the entry index width.
REQ-005 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port rdy, input, 1, global enable; no state change while low.
REQ-008 SHALL have ports alloc_valid (input, 1), alloc_ready (output, 1), alloc_rd (input, RD_W), alloc_idx (output, IDX_W): allocation handshake, destination register, and index granted (equal to tail).
REQ-009 SHALL have ports wb_valid (input, 1), wb_idx (input, IDX_W), wb_value (input, DATA_W): result writeback from execution.
REQ-010 SHALL have ports commit_valid (output, 1), commit_ready (input, 1), commit_rd (output, RD_W), commit_value (output, DATA_W), commit_idx (output, IDX_W): in-order retirement handshake.
REQ-011 SHALL have ports count (output, IDX_W+1), occupied entries, and empty (output, 1), asserted when count is 0.

Function
REQ-012 SHALL keep per-entry state: busy, done, rd, value; head and tail pointers IDX_W bits wide, wrapping modulo DEPTH.
REQ-013 SHALL drive alloc_ready = (count != DEPTH) combinationally, independent of alloc_valid and of a same-cycle commit (no full-to-full pass-through).
REQ-014 SHALL, on alloc_valid && alloc_ready && rdy: write busy=1, done=0, and rd=alloc_rd at tail, then advance tail by 1.
REQ-015 SHALL, on wb_valid && rdy with busy[wb_idx]=1: write value=wb_value and done=1; writeback to a non-busy index is ignored.
REQ-016 SHALL drive commit_valid = busy[head] && done[head], with commit_rd, commit_value and commit_idx taken from head; all combinational.
REQ-017 SHALL, on commit_valid && commit_ready && rdy: clear busy[head] and advance head by 1.
REQ-018 SHALL make a writeback in cycle N visible on commit_valid no earlier than cycle N+1; there is no same-cycle bypass.
REQ-019 SHALL update count by +1 on allocate only, -1 on commit only, and 0 on both or neither.
REQ-020 SHALL allow allocate, writeback and commit in the same cycle on distinct indices.
REQ-021 SHALL, when writeback targets the head entry while commit_valid=0, assert commit_valid the next cycle.
REQ-022 SHALL hold commit outputs stable while commit_valid=1 and commit_ready=0.

Reset
REQ-023 SHALL, when rst=1 at a clock edge (regardless of rdy), set head=0, tail=0, count=0, and clear all busy and done bits; rd and value need no reset.
REQ-024 SHALL present alloc_ready=1, commit_valid=0, empty=1, count=0 and alloc_idx=0 in the cycle after reset.
REQ-025 SHALL discard all in-flight entries on reset mid-operation; writebacks and commits in the reset cycle are ignored.

Configuration
REQ-026 SHALL gate the speculative flush feature with macro ROB_FLUSH_EN.
REQ-027 SHALL, with ROB_FLUSH_EN defined, add port flush (input, 1); flush && rdy SHALL act as reset of head, tail, count, busy and done, take priority over same-cycle allocate, writeback and commit, and force commit_valid=0 and alloc_ready=0 combinationally in the flush cycle.
REQ-028 SHALL, without ROB_FLUSH_EN, omit the flush port and flush logic entirely, with all other behaviour identical.

Verification (DEPTH=4, DATA_W=32)
REQ-029 SHALL verify in-order retirement: allocate rd=1,2,3; writeback idx2=0x33, idx0=0x11, idx1=0x22 -> commits in order (1,0x11),(2,0x22),(3,0x33), then empty=1.
REQ-030 SHALL verify the full boundary: 4 allocations -> count=4, alloc_ready=0; a 5th alloc_valid is dropped; commit one -> alloc_ready=1; the next allocation gets alloc_idx=0 (wrap).
REQ-031 SHALL verify simultaneous events: count=2 with head done, commit + allocate + writeback in one cycle -> count stays 2, tail+1, head+1, written entry done.
REQ-032 SHALL verify pause: rdy=0 for 3 cycles with all valids high -> no change in count, head or tail; commit outputs held.
REQ-033 SHALL verify reset and flush: rst (and, with ROB_FLUSH_EN, flush) with 3 entries busy -> next cycle count=0, empty=1, commit_valid=0; a stale writeback to idx1 is ignored.
